// File: rtl/rv32_wb_pkg.sv
// -----------------------------------------------------------------------------
// rv32_wb_pkg
// Shared widths, the register-file writeback entry type and the x0 constant
// for the RV32IM register-file writeback/hazard controller.
// -----------------------------------------------------------------------------
package rv32_wb_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   // x0 is hard-wired to zero: never busy, never written.
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   // One pending register-file write: destination and value.
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage : rv32_wb_pkg

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous DEPTH-entry FIFO of wb_entry_t that buffers mul/div results
// until the writeback port is free.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset; empties the FIFO
//   i_push   write i_data at the edge (ignored when full)
//   i_data   entry to write
//   i_pop    drop the head at the edge (ignored when empty)
//   o_head   current head entry (valid when !o_empty)
//   o_full   DEPTH entries held
//   o_empty  no entries held
// -----------------------------------------------------------------------------
module wb_fifo
   import rv32_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_push,
   input  wb_entry_t i_data,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   wb_entry_t      r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop  && !o_empty;
   assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are live, so stale contents are never observed.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
   end

endmodule : wb_fifo

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
// Writer/hazard side of the RV32IM 32x32 register file. Keeps a per-register
// busy scoreboard, stalls issue on RAW/WAW hazards, and arbitrates the ALU
// and buffered mul/div results onto the single register-file write port.
//
// Ports:
//   CLOCK, RESET                 rising-edge clock, async active-high reset
//   ISSUE_VALID/RD/RS1/RS2       instruction presented by decode
//   ISSUE_USES_RS1/RS2           source operand is real
//   STALL                        combinational: issue not accepted this cycle
//   ALU_WB_VALID/RD/DATA         single-cycle result, always accepted
//   MD_WB_VALID/RD/DATA          mul/div result, handshaked with MD_WB_READY
//   MD_WB_READY                  FIFO can accept a mul/div result
//   RF_WRITE/RF_INADDRESS/RF_IN  registered register-file write port
//   BUSY                         scoreboard, bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_wb_ctrl
   import rv32_wb_pkg::*;
#(
   parameter int DATA_W   = rv32_wb_pkg::DATA_W,
   parameter int ADDR_W   = rv32_wb_pkg::ADDR_W,
   parameter int MD_DEPTH = 2
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                ISSUE_VALID,
   input  logic [ADDR_W-1:0]   ISSUE_RD,
   input  logic [ADDR_W-1:0]   ISSUE_RS1,
   input  logic [ADDR_W-1:0]   ISSUE_RS2,
   input  logic                ISSUE_USES_RS1,
   input  logic                ISSUE_USES_RS2,
   output logic                STALL,
   input  logic                ALU_WB_VALID,
   input  logic [ADDR_W-1:0]   ALU_WB_RD,
   input  logic [DATA_W-1:0]   ALU_WB_DATA,
   input  logic                MD_WB_VALID,
   input  logic [ADDR_W-1:0]   MD_WB_RD,
   input  logic [DATA_W-1:0]   MD_WB_DATA,
   output logic                MD_WB_READY,
   output logic                RF_WRITE,
   output logic [ADDR_W-1:0]   RF_INADDRESS,
   output logic [DATA_W-1:0]   RF_IN,
   output logic [NUM_REGS-1:0] BUSY
);

   logic [NUM_REGS-1:0] r_busy;
   logic                r_rf_write;
   logic [ADDR_W-1:0]   r_rf_addr;
   logic [DATA_W-1:0]   r_rf_data;

   logic [NUM_REGS-1:0] w_busy_next;
   logic                w_issue_accept;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_sel_valid;
   logic                w_sel_write;
   wb_entry_t           w_head;
   wb_entry_t           w_sel;

   // ---------------- mul/div buffer ----------------
   // No full-bypass: READY depends only on the stored count.
   assign MD_WB_READY = !w_fifo_full && !RESET;
   assign w_push      = MD_WB_VALID && MD_WB_READY;

   wb_fifo #(
      .DEPTH (MD_DEPTH)
   ) u_md_fifo (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_push  (w_push),
      .i_data  (wb_entry_t'{rd: MD_WB_RD, data: MD_WB_DATA}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // ---------------- writeback arbiter ----------------
   // ALU first; the FIFO head only goes when the ALU is idle. A fresh push is
   // never visible at the head in the same cycle, so there is no MD bypass.
   assign w_pop       = !ALU_WB_VALID && !w_fifo_empty;
   assign w_sel_valid = ALU_WB_VALID || !w_fifo_empty;
   assign w_sel       = ALU_WB_VALID ? wb_entry_t'{rd: ALU_WB_RD, data: ALU_WB_DATA}
                                     : w_head;
   // Entries for x0 are consumed but never reach the register file.
   assign w_sel_write = w_sel_valid && (w_sel.rd != REG_ZERO);

   // ---------------- hazard detection ----------------
   assign STALL = ISSUE_VALID &&
                  ((ISSUE_USES_RS1 && r_busy[ISSUE_RS1]) ||
                   (ISSUE_USES_RS2 && r_busy[ISSUE_RS2]) ||
                   r_busy[ISSUE_RD]);
   assign w_issue_accept = ISSUE_VALID && !STALL;

   // Clear follows the register-file commit; a set at the same index is
   // applied afterwards so it wins.
   // NOTE: every always_comb output gets a full default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      w_busy_next = r_busy;
      if (r_rf_write) w_busy_next[r_rf_addr] = 1'b0;
      if (w_issue_accept && (ISSUE_RD != REG_ZERO)) w_busy_next[ISSUE_RD] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_busy     <= '0;
         r_rf_write <= 1'b0;
         r_rf_addr  <= '0;
         r_rf_data  <= '0;
      end else begin
         r_busy     <= w_busy_next;
         r_rf_write <= w_sel_write;
         // Address/data hold their last written values while idle.
         if (w_sel_write) begin
            r_rf_addr <= w_sel.rd;
            r_rf_data <= w_sel.data;
         end
      end
   end

   assign BUSY         = r_busy;
   assign RF_WRITE     = r_rf_write;
   assign RF_INADDRESS = r_rf_addr;
   assign RF_IN        = r_rf_data;

endmodule : regfile_wb_ctrl

// File: tb/tb_regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus a random
// run, all compared against a behavioural model (bit array + queue).
// -----------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int MD_DEPTH = 2;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic              CLOCK;
   logic              RESET;
   logic              ISSUE_VALID;
   logic [ADDR_W-1:0] ISSUE_RD;
   logic [ADDR_W-1:0] ISSUE_RS1;
   logic [ADDR_W-1:0] ISSUE_RS2;
   logic              ISSUE_USES_RS1;
   logic              ISSUE_USES_RS2;
   logic              STALL;
   logic              ALU_WB_VALID;
   logic [ADDR_W-1:0] ALU_WB_RD;
   logic [DATA_W-1:0] ALU_WB_DATA;
   logic              MD_WB_VALID;
   logic [ADDR_W-1:0] MD_WB_RD;
   logic [DATA_W-1:0] MD_WB_DATA;
   logic              MD_WB_READY;
   logic              RF_WRITE;
   logic [ADDR_W-1:0] RF_INADDRESS;
   logic [DATA_W-1:0] RF_IN;
   logic [31:0]       BUSY;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit [31:0]         m_busy;
   ent_t              m_q[$];
   bit                m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;

   regfile_wb_ctrl #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MD_DEPTH (MD_DEPTH)
   ) dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .ISSUE_VALID    (ISSUE_VALID),
      .ISSUE_RD       (ISSUE_RD),
      .ISSUE_RS1      (ISSUE_RS1),
      .ISSUE_RS2      (ISSUE_RS2),
      .ISSUE_USES_RS1 (ISSUE_USES_RS1),
      .ISSUE_USES_RS2 (ISSUE_USES_RS2),
      .STALL          (STALL),
      .ALU_WB_VALID   (ALU_WB_VALID),
      .ALU_WB_RD      (ALU_WB_RD),
      .ALU_WB_DATA    (ALU_WB_DATA),
      .MD_WB_VALID    (MD_WB_VALID),
      .MD_WB_RD       (MD_WB_RD),
      .MD_WB_DATA     (MD_WB_DATA),
      .MD_WB_READY    (MD_WB_READY),
      .RF_WRITE       (RF_WRITE),
      .RF_INADDRESS   (RF_INADDRESS),
      .RF_IN          (RF_IN),
      .BUSY           (BUSY)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // ---------------- model ----------------
   function automatic bit model_stall();
      return ISSUE_VALID &&
             ((ISSUE_USES_RS1 && m_busy[ISSUE_RS1]) ||
              (ISSUE_USES_RS2 && m_busy[ISSUE_RS2]) ||
              m_busy[ISSUE_RD]);
   endfunction

   task automatic model_reset();
      m_busy = '0;
      m_q.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   // Applies one clock edge worth of rules to the model, from current inputs.
   task automatic model_edge();
      ent_t              e;
      bit                sel;
      bit                room;
      bit                stall_now;
      logic [ADDR_W-1:0] srd;
      logic [DATA_W-1:0] sdat;
      room      = (m_q.size() < MD_DEPTH);
      stall_now = model_stall();
      sel  = 1'b0;
      srd  = '0;
      sdat = '0;
      if (ALU_WB_VALID) begin
         sel = 1'b1; srd = ALU_WB_RD; sdat = ALU_WB_DATA;
      end else if (m_q.size() != 0) begin
         e = m_q.pop_front();
         sel = 1'b1; srd = e.rd; sdat = e.data;
      end
      if (MD_WB_VALID && room) m_q.push_back('{rd: MD_WB_RD, data: MD_WB_DATA});
      if (m_we) m_busy[m_addr] = 1'b0;
      if (ISSUE_VALID && !stall_now && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1'b1;
      m_we = sel && (srd != 0);
      if (m_we) begin
         m_addr = srd;
         m_data = sdat;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      ISSUE_VALID = 0; ISSUE_RD = '0; ISSUE_RS1 = '0; ISSUE_RS2 = '0;
      ISSUE_USES_RS1 = 0; ISSUE_USES_RS2 = 0;
      ALU_WB_VALID = 0; ALU_WB_RD = '0; ALU_WB_DATA = '0;
      MD_WB_VALID = 0; MD_WB_RD = '0; MD_WB_DATA = '0;
   endtask

   task automatic issue(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                        input logic [ADDR_W-1:0] rs2, input bit u1, input bit u2);
      ISSUE_VALID = 1; ISSUE_RD = rd; ISSUE_RS1 = rs1; ISSUE_RS2 = rs2;
      ISSUE_USES_RS1 = u1; ISSUE_USES_RS2 = u2;
   endtask

   // Advance one edge; outputs settle 1 time unit later.
   task automatic tick();
      @(posedge CLOCK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      idle();
      RESET = 1'b1;
      model_reset();
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (BUSY !== 32'h0 || RF_WRITE !== 1'b0 || RF_INADDRESS !== '0 || RF_IN !== '0) begin
         errors++;
         $display("FAIL reset_state: BUSY=%h WE=%b A=%0d D=%h, want 0/0/0/0",
                  BUSY, RF_WRITE, RF_INADDRESS, RF_IN);
      end
      checks++;
      if (MD_WB_READY !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", MD_WB_READY);
      end
      // Build state mid-stream: BUSY = 0x6, FIFO holding two entries.
      issue(1, 0, 0, 0, 0); tick();
      issue(2, 0, 0, 0, 0); tick();
      ISSUE_VALID = 0;
      ALU_WB_VALID = 1; ALU_WB_RD = 10; ALU_WB_DATA = 32'h1;
      MD_WB_VALID = 1; MD_WB_RD = 11; MD_WB_DATA = 32'hAA; tick();
      MD_WB_DATA = 32'hBB; tick();
      checks++;
      if (BUSY !== 32'h6 || MD_WB_READY !== 1'b0) begin
         errors++; $display("FAIL midstream_setup: BUSY=%h READY=%b want 6/0", BUSY, MD_WB_READY);
      end
      #2;
      RESET = 1'b1;
      #1;
      checks++;
      if (BUSY !== 32'h0 || RF_WRITE !== 1'b0 || MD_WB_READY !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: BUSY=%h WE=%b READY=%b want 0/0/0", BUSY, RF_WRITE, MD_WB_READY);
      end
      idle();
      model_reset();
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      #1;
      checks++;
      if (MD_WB_READY !== 1'b1) begin
         errors++; $display("FAIL ready_after_reset: got %b want 1", MD_WB_READY);
      end
      tick();
      checks++;
      if (RF_WRITE !== 1'b0) begin
         errors++; $display("FAIL fifo_empty_after_reset: RF_WRITE=%b want 0", RF_WRITE);
      end
   endtask

   task automatic test_raw_stall();
      do_reset();
      issue(5, 0, 0, 0, 0); tick();
      issue(6, 5, 0, 1, 0);
      #1;
      checks++;
      if (STALL !== 1'b1) begin
         errors++; $display("FAIL raw_stall: STALL=%b want 1", STALL);
      end
      ALU_WB_VALID = 1; ALU_WB_RD = 5; ALU_WB_DATA = 95; tick();
      ALU_WB_VALID = 0;
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 5 || RF_IN !== 95 || BUSY[5] !== 1'b1) begin
         errors++;
         $display("FAIL raw_wb: WE=%b A=%0d D=%0d B5=%b want 1/5/95/1", RF_WRITE, RF_INADDRESS, RF_IN, BUSY[5]);
      end
      #1;
      checks++;
      if (STALL !== 1'b1) begin
         errors++; $display("FAIL raw_stall_hold: STALL=%b want 1", STALL);
      end
      tick();
      checks++;
      if (BUSY[5] !== 1'b0 || STALL !== 1'b0) begin
         errors++; $display("FAIL raw_release: B5=%b STALL=%b want 0/0", BUSY[5], STALL);
      end
      tick();
      ISSUE_VALID = 0;
      checks++;
      if (BUSY !== 32'h40) begin
         errors++; $display("FAIL raw_issue_after: BUSY=%h want 00000040", BUSY);
      end
   endtask

   task automatic test_arbitration();
      do_reset();
      issue(1, 0, 0, 0, 0); tick();
      issue(4, 0, 0, 0, 0); tick();
      ISSUE_VALID = 0;
      ALU_WB_VALID = 1; ALU_WB_RD = 1; ALU_WB_DATA = 28;
      MD_WB_VALID = 1; MD_WB_RD = 4; MD_WB_DATA = 6; tick();
      ALU_WB_VALID = 0; MD_WB_VALID = 0;
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 1 || RF_IN !== 28 || BUSY !== 32'h12) begin
         errors++;
         $display("FAIL arb_first: WE=%b A=%0d D=%0d BUSY=%h want 1/1/28/12", RF_WRITE, RF_INADDRESS, RF_IN, BUSY);
      end
      tick();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 4 || RF_IN !== 6 || BUSY !== 32'h10) begin
         errors++;
         $display("FAIL arb_second: WE=%b A=%0d D=%0d BUSY=%h want 1/4/6/10", RF_WRITE, RF_INADDRESS, RF_IN, BUSY);
      end
      tick();
      checks++;
      if (RF_WRITE !== 1'b0 || BUSY !== 32'h0 || RF_INADDRESS !== 4 || RF_IN !== 6) begin
         errors++;
         $display("FAIL arb_done: WE=%b BUSY=%h A=%0d D=%0d want 0/0/4/6", RF_WRITE, BUSY, RF_INADDRESS, RF_IN);
      end
   endtask

   task automatic test_fifo_full();
      bit exp_ready [4];
      exp_ready[0] = 1; exp_ready[1] = 1; exp_ready[2] = 0; exp_ready[3] = 0;
      do_reset();
      MD_WB_VALID = 1; MD_WB_RD = 8; MD_WB_DATA = 15;
      for (int i = 0; i < 4; i++) begin
         ALU_WB_VALID = 1; ALU_WB_RD = 7; ALU_WB_DATA = 100 + i;
         #1;
         checks++;
         if (MD_WB_READY !== exp_ready[i]) begin
            errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, MD_WB_READY, exp_ready[i]);
         end
         tick();
         if (i == 0) begin
            MD_WB_RD = 9; MD_WB_DATA = 50;
         end
      end
      ALU_WB_VALID = 0; MD_WB_VALID = 0;
      tick();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 8 || RF_IN !== 15) begin
         errors++; $display("FAIL drain_first: WE=%b A=%0d D=%0d want 1/8/15", RF_WRITE, RF_INADDRESS, RF_IN);
      end
      tick();
      checks++;
      if (RF_WRITE !== 1'b1 || RF_INADDRESS !== 9 || RF_IN !== 50 || MD_WB_READY !== 1'b1) begin
         errors++;
         $display("FAIL drain_second: WE=%b A=%0d D=%0d READY=%b want 1/9/50/1", RF_WRITE, RF_INADDRESS, RF_IN, MD_WB_READY);
      end
   endtask

   task automatic test_x0();
      do_reset();
      issue(0, 0, 0, 0, 0); tick();
      ISSUE_VALID = 0;
      checks++;
      if (BUSY !== 32'h0) begin
         errors++; $display("FAIL x0_issue: BUSY=%h want 0", BUSY);
      end
      ALU_WB_VALID = 1; ALU_WB_RD = 0; ALU_WB_DATA = 7; tick();
      ALU_WB_VALID = 0;
      checks++;
      if (RF_WRITE !== 1'b0) begin
         errors++; $display("FAIL x0_write: RF_WRITE=%b want 0", RF_WRITE);
      end
      issue(0, 0, 0, 1, 1);
      #1;
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL x0_stall: STALL=%b want 0", STALL);
      end
      idle();
   endtask

   task automatic test_waw();
      do_reset();
      issue(3, 0, 0, 0, 0); tick();
      checks++;
      if (BUSY !== 32'h8) begin
         errors++; $display("FAIL waw_first: BUSY=%h want 00000008", BUSY);
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (STALL !== 1'b1) begin
            errors++; $display("FAIL waw_stall[%0d]: STALL=%b want 1", i, STALL);
         end
         tick();
      end
      ALU_WB_VALID = 1; ALU_WB_RD = 3; ALU_WB_DATA = 33; tick();
      ALU_WB_VALID = 0;
      checks++;
      if (STALL !== 1'b1 || RF_WRITE !== 1'b1) begin
         errors++; $display("FAIL waw_commit: STALL=%b WE=%b want 1/1", STALL, RF_WRITE);
      end
      tick();
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL waw_release: STALL=%b want 0", STALL);
      end
      tick();
      ISSUE_VALID = 0;
      checks++;
      if (BUSY !== 32'h8) begin
         errors++; $display("FAIL waw_reissue: BUSY=%h want 00000008", BUSY);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         ISSUE_VALID    = ($urandom_range(0, 3) != 0);
         ISSUE_RD       = ADDR_W'($urandom_range(0, 7));
         ISSUE_RS1      = ADDR_W'($urandom_range(0, 7));
         ISSUE_RS2      = ADDR_W'($urandom_range(0, 7));
         ISSUE_USES_RS1 = $urandom_range(0, 1);
         ISSUE_USES_RS2 = $urandom_range(0, 1);
         ALU_WB_VALID   = ($urandom_range(0, 2) == 0);
         ALU_WB_RD      = ADDR_W'($urandom_range(0, 7));
         ALU_WB_DATA    = $urandom;
         MD_WB_VALID    = ($urandom_range(0, 1) == 0);
         MD_WB_RD       = ADDR_W'($urandom_range(0, 7));
         MD_WB_DATA     = $urandom;
         #1;
         checks++;
         if (STALL !== model_stall()) begin
            errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, STALL, model_stall());
         end
         checks++;
         if (MD_WB_READY !== (m_q.size() < MD_DEPTH)) begin
            errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, MD_WB_READY, m_q.size() < MD_DEPTH);
         end
         tick();
         checks++;
         if (RF_WRITE !== m_we || RF_INADDRESS !== m_addr || RF_IN !== m_data) begin
            errors++;
            $display("FAIL rnd_rf[%0d]: WE=%b A=%0d D=%h want %b/%0d/%h",
                     n, RF_WRITE, RF_INADDRESS, RF_IN, m_we, m_addr, m_data);
         end
         checks++;
         if (BUSY !== m_busy) begin
            errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, BUSY, m_busy);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      RESET = 1'b1;
      model_reset();
      #2;
      test_reset();
      test_raw_stall();
      test_arbitration();
      test_fifo_full();
      test_x0();
      test_waw();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_wb_ctrl

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writer/hazard side of the RV32IM 32x32 register file.
- Tracks a per-register busy scoreboard for issued instructions and stalls issue on RAW/WAW hazards.
- Arbitrates writeback from the single-cycle ALU path and the multi-cycle mul/div unit onto the register file's single write port (IN/INADDRESS/WRITE).
- The mul/div path is buffered in a small FIFO.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- MD_DEPTH, 2, mul/div writeback FIFO entries (power of two, >=2).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ISSUE_VALID  in  1  decode presents an instruction this cycle.
- ISSUE_RD  in  ADDR_W  destination register of the issuing instruction.
- ISSUE_RS1  in  ADDR_W  first source register.
- ISSUE_RS2  in  ADDR_W  second source register.
- ISSUE_USES_RS1  in  1  rs1 is a real operand.
- ISSUE_USES_RS2  in  1  rs2 is a real operand.
- STALL  out  1  combinational; issue is not accepted this cycle.
- ALU_WB_VALID  in  1  ALU result valid; always accepted.
- ALU_WB_RD  in  ADDR_W  ALU destination.
- ALU_WB_DATA  in  DATA_W  ALU result.
- MD_WB_VALID  in  1  mul/div result valid.
- MD_WB_RD  in  ADDR_W  mul/div destination.
- MD_WB_DATA  in  DATA_W  mul/div result.
- MD_WB_READY  out  1  FIFO can accept; a transfer occurs when VALID && READY at a rising edge.
- RF_WRITE  out  1  registered; drives register file WRITE.
- RF_INADDRESS  out  ADDR_W  registered; drives INADDRESS.
- RF_IN  out  DATA_W  registered; drives IN.
- BUSY  out  32  scoreboard vector; bit 0 is constant 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - BUSY=0, FIFO emptied and its contents discarded.
  - RF_WRITE=0, RF_INADDRESS=0, RF_IN=0.
  - MD_WB_READY=0 while RESET is high.
- STALL = ISSUE_VALID && ((USES_RS1 && BUSY[RS1]) || (USES_RS2 && BUSY[RS2]) || BUSY[RD]). Because bit 0 is never busy, x0 never stalls.
- Issue acceptance: when ISSUE_VALID && !STALL, set BUSY[ISSUE_RD] at the next edge, unless RD=0.
- Writeback selection, evaluated each cycle:
  - Priority 1: ALU_WB_VALID.
  - Priority 2: FIFO non-empty (pop the head).
  - Otherwise idle.
  - At the edge, RF_WRITE <= selected && rd!=0; RF_INADDRESS/RF_IN <= selected rd/data.
  - When RF_WRITE=0, RF_INADDRESS/RF_IN hold their previous values.
- FIFO push: at an edge with MD_WB_VALID && MD_WB_READY.
  - MD_WB_READY = !full && !RESET; there is no full-bypass.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no direct MD-to-RF bypass: a pushed entry is eligible no earlier than the next cycle.
  - A push with rd=0 is accepted, and is dropped when it is popped.
- Busy clear: at an edge where RF_WRITE=1, clear BUSY[RF_INADDRESS]. This coincides with the register file commit edge.
  - If a set and a clear hit the same index at the same edge, set wins (unreachable in legal flow because of WAW stalling).
- Latency:
  - ALU result sampled at edge N → RF_WRITE high in cycle N..N+1 → RF commit and busy clear at edge N+1 → STALL on that register drops in the cycle after edge N+1.
  - MD result pushed at edge N, with no ALU contention → RF_WRITE high after edge N+1 → busy clear at edge N+2.
- ALU starvation of the FIFO is allowed. The FIFO fills and MD_WB_READY back-pressures the mul/div unit.
- A writeback to a non-busy register still writes, and the busy clear is a no-op.

Decomposition:
- Shared package rv32_wb_pkg:
  - DATA_W, ADDR_W, NUM_REGS=32.
  - wb_entry_t {rd[ADDR_W], data[DATA_W]}.
  - Constant REG_ZERO=0.
- Sub-module wb_fifo: synchronous MD_DEPTH-entry FIFO of wb_entry_t, with async reset, push/pop, full/empty, and head output.
- Scoreboard, stall logic and arbiter stay in the top module.

Test Plan:
- Reset mid-stream: FIFO holds 2 entries and BUSY=0x0000_0006, assert RESET → BUSY=0, RF_WRITE=0, MD_WB_READY=0 immediately, FIFO empty after release.
- RAW stall: issue rd=5, then issue rs1=5 → STALL=1. ALU_WB rd=5 data=95 → RF_WRITE=1 INADDRESS=5 IN=95, BUSY[5] clears one edge later, STALL=0 the following cycle.
- Arbitration: ALU_WB (rd=1, 28) and MD_WB (rd=4, 6) in the same cycle → RF writes rd=1 first, rd=4 next cycle, both BUSY bits cleared in order.
- FIFO full: hold ALU_WB_VALID=1 for 4 cycles with MD_WB_VALID=1 → MD_WB_READY drops after 2 pushes. Release the ALU → entries drain FIFO order (15 then 50).
- x0 handling: issue rd=0 → BUSY unchanged. ALU_WB rd=0 data=7 → RF_WRITE stays 0. Issue rs1=0 rs2=0 → STALL=0.
- WAW: issue rd=3 accepted, second issue rd=3 → STALL=1 until writeback of rd=3 commits.
